// File: rtl/alsu_pipe.sv
// Pipelined arithmetic/logic/shift unit: capture stage, decode/compute stage, commit stage.
// Shift and rotate resolve at commit against the live out register so back-to-back ops chain.
module alsu_pipe #(
    parameter int    WIDTH          = 8,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_WIDTH      = 16,
    parameter int    ERR_CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic [2:0]             opcode,
    input  logic                   cin,
    input  logic                   serial_in,
    input  logic                   direction,
    input  logic                   red_op_A,
    input  logic                   red_op_B,
    input  logic                   bypass_A,
    input  logic                   bypass_B,
    output logic [2*WIDTH-1:0]     out,
    output logic                   out_valid,
    output logic                   invalid,
    output logic [LED_WIDTH-1:0]   leds,
    output logic [ERR_CNT_W-1:0]   err_count
);

    localparam int OW      = 2 * WIDTH;
    localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    // Handshake: in_valid qualifies every input on the edge it is sampled; there is no
    // backpressure. out_valid is a one-cycle pulse on the cycle out/invalid were updated.

    typedef enum logic [1:0] {
        K_LOAD    = 2'd0,
        K_SHIFT   = 2'd1,
        K_ROT     = 2'd2,
        K_INVALID = 2'd3
    } kind_e;

    // Stage 1 capture registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_opcode_q, s1_opcode_d;
    logic             s1_cin_q, s1_cin_d;
    logic             s1_serial_q, s1_serial_d;
    logic             s1_dir_q, s1_dir_d;
    logic             s1_red_a_q, s1_red_a_d;
    logic             s1_red_b_q, s1_red_b_d;
    logic             s1_byp_a_q, s1_byp_a_d;
    logic             s1_byp_b_q, s1_byp_b_d;

    // Stage 2 decoded operation
    logic             s2_valid_q, s2_valid_d;
    kind_e            s2_kind_q, s2_kind_d;
    logic [OW-1:0]    s2_res_q, s2_res_d;
    logic             s2_dir_q, s2_dir_d;
    logic             s2_serial_q, s2_serial_d;

    // Committed outputs
    logic [OW-1:0]        out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 invalid_q, invalid_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        s1_valid_d  = in_valid;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_opcode_d = s1_opcode_q;
        s1_cin_d    = s1_cin_q;
        s1_serial_d = s1_serial_q;
        s1_dir_d    = s1_dir_q;
        s1_red_a_d  = s1_red_a_q;
        s1_red_b_d  = s1_red_b_q;
        s1_byp_a_d  = s1_byp_a_q;
        s1_byp_b_d  = s1_byp_b_q;
        if (in_valid) begin
            s1_a_d      = A;
            s1_b_d      = B;
            s1_opcode_d = opcode;
            s1_cin_d    = cin;
            s1_serial_d = serial_in;
            s1_dir_d    = direction;
            s1_red_a_d  = red_op_A;
            s1_red_b_d  = red_op_B;
            s1_byp_a_d  = bypass_A;
            s1_byp_b_d  = bypass_B;
        end
    end

    logic             byp_any, red_any, byp_use_b, red_use_b, bad_op;
    logic [WIDTH-1:0] byp_operand, red_operand;
    logic [WIDTH:0]   sum;
    logic [OW-1:0]    prod;

    always_comb begin
        byp_any     = s1_byp_a_q | s1_byp_b_q;
        red_any     = s1_red_a_q | s1_red_b_q;
        // When both selects are set the INPUT_PRIORITY operand wins.
        byp_use_b   = s1_byp_b_q & (~s1_byp_a_q | PRIO_B);
        red_use_b   = s1_red_b_q & (~s1_red_a_q | PRIO_B);
        byp_operand = byp_use_b ? s1_b_q : s1_a_q;
        red_operand = red_use_b ? s1_b_q : s1_a_q;
        sum         = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, (USE_CIN && s1_cin_q)};
        prod        = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
        bad_op      = (s1_opcode_q[2:1] == 2'b11) ||
                      (red_any && (s1_opcode_q >= 3'd2) && (s1_opcode_q <= 3'd5));
    end

    always_comb begin
        s2_valid_d  = s1_valid_q;
        s2_kind_d   = s2_kind_q;
        s2_res_d    = s2_res_q;
        s2_dir_d    = s2_dir_q;
        s2_serial_d = s2_serial_q;
        if (s1_valid_q) begin
            s2_dir_d    = s1_dir_q;
            s2_serial_d = s1_serial_q;
            s2_kind_d   = K_LOAD;
            s2_res_d    = '0;
            if (byp_any) begin
                s2_res_d = {{WIDTH{1'b0}}, byp_operand};
            end else if (bad_op) begin
                s2_kind_d = K_INVALID;
            end else begin
                case (s1_opcode_q)
                    3'b000: s2_res_d = red_any ? {{(OW-1){1'b0}}, &red_operand}
                                               : {{WIDTH{1'b0}}, s1_a_q & s1_b_q};
                    3'b001: s2_res_d = red_any ? {{(OW-1){1'b0}}, ^red_operand}
                                               : {{WIDTH{1'b0}}, s1_a_q ^ s1_b_q};
                    3'b010: s2_res_d = {{(WIDTH-1){1'b0}}, sum};
                    3'b011: s2_res_d = prod;
                    3'b100: s2_kind_d = K_SHIFT;
                    3'b101: s2_kind_d = K_ROT;
                    default: s2_kind_d = K_INVALID;
                endcase
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        invalid_d   = invalid_q;
        err_count_d = err_count_q;
        leds_d      = invalid_q ? ~leds_q : '0;
        if (s2_valid_q) begin
            out_valid_d = 1'b1;
            invalid_d   = 1'b0;
            leds_d      = '0;
            case (s2_kind_q)
                K_LOAD:  out_d = s2_res_q;
                K_SHIFT: out_d = s2_dir_q ? {out_q[OW-2:0], s2_serial_q}
                                          : {s2_serial_q, out_q[OW-1:1]};
                K_ROT:   out_d = s2_dir_q ? {out_q[OW-2:0], out_q[OW-1]}
                                          : {out_q[0], out_q[OW-1:1]};
                default: begin
                    out_d       = '0;
                    invalid_d   = 1'b1;
                    leds_d      = '1;
                    err_count_d = (err_count_q == '1) ? err_count_q
                                                      : err_count_q + ERR_CNT_W'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_opcode_q <= '0;
            s1_cin_q    <= 1'b0;
            s1_serial_q <= 1'b0;
            s1_dir_q    <= 1'b0;
            s1_red_a_q  <= 1'b0;
            s1_red_b_q  <= 1'b0;
            s1_byp_a_q  <= 1'b0;
            s1_byp_b_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_kind_q   <= K_LOAD;
            s2_res_q    <= '0;
            s2_dir_q    <= 1'b0;
            s2_serial_q <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            invalid_q   <= 1'b0;
            leds_q      <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_opcode_q <= s1_opcode_d;
            s1_cin_q    <= s1_cin_d;
            s1_serial_q <= s1_serial_d;
            s1_dir_q    <= s1_dir_d;
            s1_red_a_q  <= s1_red_a_d;
            s1_red_b_q  <= s1_red_b_d;
            s1_byp_a_q  <= s1_byp_a_d;
            s1_byp_b_q  <= s1_byp_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_kind_q   <= s2_kind_d;
            s2_res_q    <= s2_res_d;
            s2_dir_q    <= s2_dir_d;
            s2_serial_q <= s2_serial_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            invalid_q   <= invalid_d;
            leds_q      <= leds_d;
            err_count_q <= err_count_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign invalid   = invalid_q;
    assign leds      = leds_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Two alsu_pipe instances (default config; priority B / no carry / 2-bit counter) share
// one stimulus stream and are compared every cycle against an arithmetic reference model.
module tb_alsu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a, b;
  logic [2:0]  opcode;
  logic        cin, serial_in, direction, red_op_a, red_op_b, bypass_a, bypass_b;

  logic [15:0] out0, out1, leds0, leds1;
  logic        ov0, ov1, inv0, inv1;
  logic [7:0]  err0;
  logic [1:0]  err1;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  alsu_pipe u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_a), .red_op_B(red_op_b), .bypass_A(bypass_a), .bypass_B(bypass_b),
    .out(out0), .out_valid(ov0), .invalid(inv0), .leds(leds0), .err_count(err0)
  );

  alsu_pipe #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .ERR_CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_a), .red_op_B(red_op_b), .bypass_A(bypass_a), .bypass_B(bypass_b),
    .out(out1), .out_valid(ov1), .invalid(inv1), .leds(leds1), .err_count(err1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic       valid;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       cin, sin, dir, ra, rb, ba, bb;
  } txn_t;

  typedef struct {
    int          inst;
    int          fld;
    logic [31:0] val;
    string       nm;
  } exp_t;

  txn_t        pipe_q[$];
  exp_t        exp_q[$];
  int unsigned m_out[2];
  logic        m_ov[2];
  logic        m_inv[2];
  logic [15:0] m_leds[2];
  int unsigned m_err[2];
  bit          model_live = 0;

  function automatic void model_apply(int i, txn_t t);
    bit          prio_b  = (i == 1);
    bit          use_cin = (i == 0);
    int unsigned err_max = (i == 0) ? 255 : 3;
    int unsigned va = t.a;
    int unsigned vb = t.b;
    int unsigned sel;
    m_ov[i] = 1'b1;
    if (t.ba || t.bb) begin
      m_out[i] = (t.ba && t.bb) ? (prio_b ? vb : va) : (t.ba ? va : vb);
      m_inv[i] = 1'b0;
      m_leds[i] = 16'h0000;
    end else if (t.op >= 6 || ((t.ra || t.rb) && t.op >= 2)) begin
      m_out[i] = 0;
      m_inv[i] = 1'b1;
      m_leds[i] = 16'hFFFF;
      if (m_err[i] < err_max) m_err[i] = m_err[i] + 1;
    end else begin
      sel = (t.ra && t.rb) ? (prio_b ? vb : va) : (t.ra ? va : vb);
      case (t.op)
        3'd0: m_out[i] = (t.ra || t.rb) ? ((sel == 255) ? 1 : 0) : (va & vb);
        3'd1: m_out[i] = (t.ra || t.rb) ? ($countones(sel) % 2) : (va ^ vb);
        3'd2: m_out[i] = va + vb + ((use_cin && t.cin) ? 1 : 0);
        3'd3: m_out[i] = va * vb;
        3'd4: m_out[i] = t.dir ? (((m_out[i] * 2) % 65536) + t.sin)
                               : ((t.sin ? 32768 : 0) + m_out[i] / 2);
        default: m_out[i] = t.dir ? (((m_out[i] * 2) % 65536) + m_out[i] / 32768)
                                  : (((m_out[i] % 2) * 32768) + m_out[i] / 2);
      endcase
      m_inv[i] = 1'b0;
      m_leds[i] = 16'h0000;
    end
  endfunction

  function automatic logic [31:0] dut_field(int i, int f);
    case (f)
      0: return (i == 0) ? {16'h0, out0} : {16'h0, out1};
      1: return (i == 0) ? {31'h0, ov0} : {31'h0, ov1};
      2: return (i == 0) ? {31'h0, inv0} : {31'h0, inv1};
      3: return (i == 0) ? {16'h0, leds0} : {16'h0, leds1};
      default: return (i == 0) ? {24'h0, err0} : {30'h0, err1};
    endcase
  endfunction

  function automatic logic [31:0] model_field(int i, int f);
    case (f)
      0: return m_out[i];
      1: return {31'h0, m_ov[i]};
      2: return {31'h0, m_inv[i]};
      3: return {16'h0, m_leds[i]};
      default: return m_err[i];
    endcase
  endfunction

  function automatic void check(string nm, int i, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endfunction

  // Compare process: advance the model on each edge, then check DUT and pinned literals.
  always @(posedge clk) begin
    txn_t t;
    if (!rst) begin
      pipe_q.delete();
      for (int i = 0; i < 2; i++) begin
        m_out[i] = 0; m_ov[i] = 0; m_inv[i] = 0; m_leds[i] = 16'h0; m_err[i] = 0;
      end
      model_live = 1;
    end else if (model_live) begin
      for (int i = 0; i < 2; i++) m_ov[i] = 1'b0;
      if (pipe_q.size() == 2) begin
        t = pipe_q.pop_front();
        if (t.valid)
          for (int i = 0; i < 2; i++) model_apply(i, t);
      end
      for (int i = 0; i < 2; i++)
        if (!m_ov[i]) m_leds[i] = m_inv[i] ? ~m_leds[i] : 16'h0;
      t.valid = in_valid; t.a = a; t.b = b; t.op = opcode; t.cin = cin; t.sin = serial_in;
      t.dir = direction; t.ra = red_op_a; t.rb = red_op_b; t.ba = bypass_a; t.bb = bypass_b;
      pipe_q.push_back(t);
    end
    #1;
    if (model_live) begin
      for (int i = 0; i < 2; i++) begin
        check("out", i, dut_field(i, 0), model_field(i, 0));
        check("out_valid", i, dut_field(i, 1), model_field(i, 1));
        check("invalid", i, dut_field(i, 2), model_field(i, 2));
        check("leds", i, dut_field(i, 3), model_field(i, 3));
        check("err_count", i, dut_field(i, 4), model_field(i, 4));
      end
    end
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.nm, "_dut"}, e.inst, dut_field(e.inst, e.fld), e.val);
      check({e.nm, "_model"}, e.inst, model_field(e.inst, e.fld), e.val);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] op,
                      input logic ci, input logic si, input logic dir,
                      input logic ra, input logic rb, input logic ba, input logic bb);
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; opcode = op; cin = ci; serial_in = si;
    direction = dir; red_op_a = ra; red_op_b = rb; bypass_a = ba; bypass_b = bb;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
  endtask

  // Expectation holds for the state right after the next rising edge.
  task automatic expect_v(int inst, int fld, logic [31:0] v, string nm);
    exp_t e;
    e.inst = inst; e.fld = fld; e.val = v; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic rand_cycle();
    @(negedge clk);
    rst       = ($urandom_range(0, 299) != 0);
    in_valid  = ($urandom_range(0, 3) != 0);
    a         = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    b         = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    opcode    = 3'($urandom_range(0, 7));
    cin       = 1'($urandom);
    serial_in = 1'($urandom);
    direction = 1'($urandom);
    red_op_a  = ($urandom_range(0, 3) == 0);
    red_op_b  = ($urandom_range(0, 3) == 0);
    bypass_a  = ($urandom_range(0, 7) == 0);
    bypass_b  = ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0; cin = 0; serial_in = 0;
    direction = 0; red_op_a = 0; red_op_b = 0; bypass_a = 0; bypass_b = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_v(i, 0, 0, "rst_out"); expect_v(i, 1, 0, "rst_ov"); expect_v(i, 2, 0, "rst_inv");
      expect_v(i, 3, 0, "rst_leds"); expect_v(i, 4, 0, "rst_err");
    end

    // multiply
    send(8'hFF, 8'h03, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    expect_v(0, 0, 32'h02FD, "mul_out"); expect_v(0, 1, 1, "mul_ov");
    expect_v(0, 2, 0, "mul_inv"); expect_v(0, 3, 0, "mul_leds");
    idle();
    expect_v(0, 1, 0, "mul_ov_pulse");

    // add with and without carry-in
    send(8'hFF, 8'h01, 3'b010, 1, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    expect_v(0, 0, 32'h0101, "add_cin_on"); expect_v(1, 0, 32'h0100, "add_cin_off");

    // load, shift, rotate chain back to back
    send(8'h03, 8'h00, 3'b000, 0, 0, 0, 0, 0, 1, 0);
    send(8'h00, 8'h00, 3'b100, 0, 1, 0, 0, 0, 0, 0);
    send(8'h00, 8'h00, 3'b101, 0, 0, 1, 0, 0, 0, 0);
    expect_v(0, 0, 32'h0003, "chain_load");
    send(8'h00, 8'h00, 3'b101, 0, 0, 1, 0, 0, 0, 0);
    expect_v(0, 0, 32'h8001, "chain_shr");
    send(8'h00, 8'h00, 3'b100, 0, 1, 0, 0, 0, 0, 0);
    expect_v(0, 0, 32'h0003, "chain_rol1"); expect_v(1, 0, 32'h0003, "chain_rol1");
    idle();
    expect_v(0, 0, 32'h0006, "chain_rol2");
    idle();
    expect_v(0, 0, 32'h8003, "chain_shr2"); expect_v(1, 0, 32'h8003, "chain_shr2");

    // invalid opcode, blinking leds, recovery with reduction xor
    send(8'h00, 8'h00, 3'b110, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    expect_v(0, 0, 0, "inv_out"); expect_v(0, 2, 1, "inv_flag");
    expect_v(0, 4, 1, "inv_err"); expect_v(0, 3, 32'hFFFF, "inv_leds1");
    idle();
    expect_v(0, 3, 32'h0000, "inv_leds2");
    idle();
    expect_v(0, 3, 32'hFFFF, "inv_leds3");
    send(8'h00, 8'h07, 3'b001, 0, 0, 0, 0, 1, 0, 0);
    idle(); idle();
    expect_v(0, 0, 1, "redxor_out"); expect_v(0, 2, 0, "redxor_inv");
    expect_v(0, 3, 0, "redxor_leds"); expect_v(1, 0, 1, "redxor_out");

    // double bypass with an invalid opcode
    send(8'h12, 8'h34, 3'b111, 0, 0, 0, 0, 0, 1, 1);
    idle(); idle();
    expect_v(1, 0, 32'h0034, "byp_prio_b"); expect_v(0, 0, 32'h0012, "byp_prio_a");
    expect_v(1, 2, 0, "byp_inv"); expect_v(1, 4, 1, "byp_err");

    // saturation of the narrow counter
    repeat (5) send(8'h00, 8'h00, 3'b111, 0, 0, 0, 1, 0, 0, 0);
    idle(); idle();
    expect_v(1, 4, 3, "err_sat"); expect_v(0, 4, 6, "err_count6");

    // reset while a transaction is in flight
    send(8'hFF, 8'hFF, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_v(i, 1, 0, "midrst_ov"); expect_v(i, 0, 0, "midrst_out");
      expect_v(i, 4, 0, "midrst_err"); expect_v(i, 3, 0, "midrst_leds");
    end
    idle();
    expect_v(0, 1, 0, "midrst_ov2");

    // randomized traffic
    for (int n = 0; n < 3000; n++) rand_cycle();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
